// File: rtl/block_check_sched.sv
// -----------------------------------------------------------------------------
// block_check_sched
//
// Shares one BlockChecker (begin/end nesting checker, one ASCII char per clock,
// no enable) between two byte-stream requesters. A whole job is buffered
// first, then the checker is cleared and fed the job without gaps, followed by
// a terminating space. The checker result is sampled and reported together
// with the requester id, the received length and an overflow flag.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   reqN_valid/data/last  requester N byte stream (N = 0, 1)
//   reqN_ready            requester N byte accepted this cycle
//   chk_reset, chk_in     reset and character input driven into the checker
//   chk_result            checker verdict
//   busy                  a job is in progress
//   done                  one-cycle completion pulse
//   done_id/result/len/ovf  report of the last completed job (held)
// -----------------------------------------------------------------------------
module block_check_sched #(
  parameter int DEPTH      = 64,  // job buffer size in bytes, power of 2, >= 2
  parameter int RESULT_LAT = 1    // checker result latency in cycles, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        chk_reset,
  output logic [7:0]  chk_in,
  input  logic        chk_result,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic        done_result,
  output logic [15:0] done_len,
  output logic        done_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESULT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_REPLAY, S_FLUSH, S_WAIT, S_REPORT
  } state_t;

  state_t        state, state_nxt;
  logic          grant;      // requester owning the current job
  logic          rr_last;    // requester served by the previous job
  logic [AW:0]   wr_ptr;     // one extra bit so "buffer full" is representable
  logic [AW-1:0] rd_ptr;
  logic [15:0]   len;
  logic          ovf;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    mem [DEPTH];

  logic          any_valid;
  logic          grant_nxt;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          beat;
  logic          buf_full;
  logic [AW:0]   last_idx;
  logic          replay_end;

  assign any_valid = req0_valid | req1_valid;
  // With both requesting, the one not served last time wins.
  assign grant_nxt = (req0_valid & req1_valid) ? ~rr_last : req1_valid;

  assign sel_valid = grant ? req1_valid : req0_valid;
  assign sel_last  = grant ? req1_last  : req0_last;
  assign sel_data  = grant ? req1_data  : req0_data;
  assign beat      = (state == S_LOAD) & sel_valid;

  // wr_ptr stops exactly at DEPTH, so its top bit alone flags a full buffer.
  assign buf_full   = wr_ptr[AW];
  // wr_ptr equals the stored byte count, min(len, DEPTH), which is >= 1.
  assign last_idx   = wr_ptr - (AW + 1)'(1);
  assign replay_end = ({1'b0, rd_ptr} == last_idx);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state-holding processes use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_valid)           state_nxt = S_LOAD;
      S_LOAD:   if (beat && sel_last)    state_nxt = S_CLEAR;
      S_CLEAR:                           state_nxt = S_REPLAY;
      S_REPLAY: if (replay_end)          state_nxt = S_FLUSH;
      S_FLUSH:                           state_nxt = S_WAIT;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_REPORT;
      S_REPORT:                          state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // The checker stays cleared while idle so stray input never accumulates.
    chk_reset  = reset | (state == S_IDLE) | (state == S_CLEAR);
    chk_in     = (state == S_REPLAY) ? mem[rd_ptr] : 8'h20;
    req0_ready = (state == S_LOAD) & ~grant;
    req1_ready = (state == S_LOAD) &  grant;
    busy       = (state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= 1'b0;
      rr_last     <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      ovf         <= 1'b0;
      wait_cnt    <= '0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      done_result <= 1'b0;
      done_len    <= '0;
      done_ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) grant <= grant_nxt;
        end
        S_LOAD: begin
          if (beat) begin
            if (!buf_full) wr_ptr <= wr_ptr + (AW + 1)'(1);
            else           ovf    <= 1'b1;
            if (len != 16'hFFFF) len <= len + 16'd1;
          end
        end
        S_CLEAR:  rd_ptr   <= '0;
        S_REPLAY: rd_ptr   <= rd_ptr + AW'(1);
        S_FLUSH:  wait_cnt <= '0;
        S_WAIT:   wait_cnt <= wait_cnt + WW'(1);
        S_REPORT: begin
          done        <= 1'b1;
          done_result <= chk_result;
          done_id     <= grant;
          done_len    <= len;
          done_ovf    <= ovf;
          rr_last     <= grant;
          len         <= '0;
          ovf         <= 1'b0;
          wr_ptr      <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the job buffer has no reset; every byte read during replay was
  // written earlier in the same job, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (beat && !buf_full) mem[wr_ptr[AW-1:0]] <= sel_data;
  end

endmodule

// File: tb/tb_block_check_sched.sv
// -----------------------------------------------------------------------------
// tb_block_check_sched
//
// Bench for block_check_sched. Contains a behavioural begin/end checker that
// plays the role of the shared BlockChecker. Expected job reports are pushed
// to a scoreboard when a job has been driven and compared against the reports
// captured on each done pulse.
// -----------------------------------------------------------------------------
module tb_block_check_sched;

  localparam int DEPTH = 64;
  localparam int RL    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid = 1'b0, req0_last = 1'b0;
  logic [7:0]  req0_data  = 8'h00;
  logic        req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0]  req1_data  = 8'h00;
  logic        req0_ready, req1_ready;
  logic        chk_reset;
  logic [7:0]  chk_in;
  logic        chk_result = 1'b0;
  logic        busy, done, done_id, done_result, done_ovf;
  logic [15:0] done_len;

  block_check_sched #(.DEPTH(DEPTH), .RESULT_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .chk_reset(chk_reset), .chk_in(chk_in), .chk_result(chk_result),
    .busy(busy), .done(done), .done_id(done_id), .done_result(done_result),
    .done_len(done_len), .done_ovf(done_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;  // number of rising edges so far

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Behavioural checker: case-insensitive words separated by spaces; "begin"
  // opens, "end" closes; verdict 1 when balanced and never underflowed.
  // The verdict is registered, i.e. one cycle behind the consumed char.
  // ---------------------------------------------------------------------------
  logic [39:0] m_w = '0;
  int          m_wlen = 0, m_depth = 0;
  logic        m_err = 1'b0;

  function automatic logic [7:0] lc(input logic [7:0] c);
    return (c >= "A" && c <= "Z") ? c + 8'h20 : c;
  endfunction

  always @(posedge clk) begin
    if (chk_reset) begin
      m_w <= '0; m_wlen <= 0; m_depth <= 0; m_err <= 1'b0;
    end else if (chk_in == 8'h20) begin
      if (m_wlen == 5 && m_w == "begin") m_depth <= m_depth + 1;
      else if (m_wlen == 3 && m_w[23:0] == "end") begin
        if (m_depth == 0) m_err <= 1'b1;
        else              m_depth <= m_depth - 1;
      end
      m_w <= '0; m_wlen <= 0;
    end else begin
      m_w <= {m_w[31:0], lc(chk_in)};
      if (m_wlen < 6) m_wlen <= m_wlen + 1;
    end
    chk_result <= !m_err && (m_depth == 0);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard records
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        id;
    logic        res;
    logic [15:0] len;
    logic        ovf;
    logic [31:0] edge_c;     // rising edge on which done went high
    logic [15:0] own_acc;    // beats accepted from the served requester
    logic [15:0] other_rdy;  // ready cycles seen by the other requester
  } rec_t;

  rec_t  exp_q[$], obs_q[$];
  string exp_cap_q[$], obs_cap_q[$];

  // Monitor: captures what the checker consumed since its last reset, and
  // per-requester ready/accept activity since the previous report.
  string cap = "";
  int    rdy0 = 0, rdy1 = 0, acc0 = 0, acc1 = 0;

  always @(negedge clk) begin
    if (reset) begin
      cap <= ""; rdy0 <= 0; rdy1 <= 0; acc0 <= 0; acc1 <= 0;
    end else begin
      if (done) begin
        obs_q.push_back(rec_t'{id: done_id, res: done_result, len: done_len, ovf: done_ovf,
                               edge_c: cyc, own_acc: 16'(done_id ? acc1 : acc0),
                               other_rdy: 16'(done_id ? rdy0 : rdy1)});
        obs_cap_q.push_back(cap);
        rdy0 <= 0; rdy1 <= 0; acc0 <= 0; acc1 <= 0;
      end else begin
        rdy0 <= rdy0 + int'(req0_ready);
        rdy1 <= rdy1 + int'(req1_ready);
        acc0 <= acc0 + int'(req0_ready & req0_valid);
        acc1 <= acc1 + int'(req1_ready & req1_valid);
      end
      cap <= chk_reset ? "" : $sformatf("%s%c", cap, chk_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic bit ref_result(input string s);
    string t = s.tolower();
    string w = "";
    int    depth = 0;
    bit    err = 1'b0;
    for (int i = 0; i <= t.len(); i++) begin
      if (i == t.len() || t[i] == " ") begin
        if (w == "begin") depth++;
        else if (w == "end") begin
          if (depth == 0) err = 1'b1;
          else            depth--;
        end
        w = "";
      end else begin
        w = {w, t.substr(i, i)};
      end
    end
    return !err && depth == 0;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("id=%0d res=%0d len=%0d ovf=%0d edge=%0d acc=%0d other_rdy=%0d",
                     r.id, r.res, r.len, r.ovf, r.edge_c, r.own_acc, r.other_rdy);
  endfunction

  // Expected report for a job whose last beat was accepted on edge l.
  task automatic push_exp(input int id, input string s, input int l);
    string stored = (s.len() > DEPTH) ? s.substr(0, DEPTH - 1) : s;
    string ecap   = stored;
    int    n      = stored.len();
    for (int k = 0; k < 2 + RL; k++) ecap = {ecap, " "};
    exp_q.push_back(rec_t'{id: id[0], res: ref_result(stored),
                           len: (s.len() > 65535) ? 16'hFFFF : 16'(s.len()),
                           ovf: (s.len() > DEPTH), edge_c: 32'(l + 3 + n + RL),
                           own_acc: 16'(s.len()), other_rdy: 16'd0});
    exp_cap_q.push_back(ecap);
  endtask

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic l);
    if (id == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
    else         begin req1_valid = v; req1_data = d; req1_last = l; end
  endtask

  // Streams s on requester id with random bubbles; returns the accept edge
  // of the last beat.
  task automatic send(input int id, input string s, input int bubble_pct, output int last_edge);
    int  i = 0;
    int  guard = 0;
    logic rdy;
    bit  bub;
    last_edge = 0;
    while (i < s.len()) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        checks++; failures++;
        $display("FAIL send_timeout id=%0d sent=%0d of %0d", id, i, s.len());
        break;
      end
      bub = (bubble_pct > 0) && ($urandom_range(0, 99) < bubble_pct);
      if (bub) drive(id, 1'b0, 8'h00, 1'b0);
      else     drive(id, 1'b1, s[i], (i == s.len() - 1));
      #1;
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (!bub && rdy) begin
        if (i == s.len() - 1) last_edge = cyc + 1;
        i++;
      end
    end
    @(negedge clk);
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, chk_reset, req0_ready, req1_ready} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_ctrl got busy,done,chk_reset,rdy0,rdy1=%b want 00100",
               {busy, done, chk_reset, req0_ready, req1_ready});
    end
    checks++;
    if ({done_id, done_result, done_ovf, done_len} !== 19'd0) begin
      failures++;
      $display("FAIL reset_report got id=%0d res=%0d ovf=%0d len=%0d want all 0",
               done_id, done_result, done_ovf, done_len);
    end
    checks++;
    if (chk_in !== 8'h20) begin
      failures++;
      $display("FAIL reset_chk_in got %h want 20", chk_in);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, chk_reset, req0_ready, req1_ready} !== 4'b0100) begin
      failures++;
      $display("FAIL idle_ctrl got busy,chk_reset,rdy0,rdy1=%b want 0100",
               {busy, chk_reset, req0_ready, req1_ready});
    end
  endtask

  // Both requesters valid in IDLE: round-robin order, other side starved of ready.
  task automatic test_arbitration();
    int l0, l1;
    bit ok;
    rec_t e, o;
    string ec, oc;
    for (int round = 0; round < 2; round++) begin
      string s0 = (round == 0) ? "begin end" : "end begin";
      string s1 = (round == 0) ? "bEgin en"  : "begin begin end end";
      fork
        send(0, s0, 0, l0);
        send(1, s1, 0, l1);
      join
      push_exp(0, s0, l0);
      push_exp(1, s1, l1);
      wait_obs(2, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL arb_timeout round=%0d reports=%0d want 2", round, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        ec = exp_cap_q.pop_front(); oc = obs_cap_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL arb_report round=%0d got %s want %s", round, fmt(o), fmt(e));
        end
        checks++;
        if (oc != ec) begin
          failures++;
          $display("FAIL arb_stream round=%0d got \"%s\" want \"%s\"", round, oc, ec);
        end
      end
      exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
    end
  endtask

  task automatic test_bubbles();
    int l;
    bit ok;
    rec_t e, o;
    string ec, oc;
    send(0, "begin end", 40, l);
    push_exp(0, "begin end", l);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bubbles_timeout no done");
    end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ec = exp_cap_q.pop_front(); oc = obs_cap_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bubbles_report got %s want %s", fmt(o), fmt(e));
      end
      checks++;
      if (oc != ec) begin
        failures++;
        $display("FAIL bubbles_stream got \"%s\" want \"%s\"", oc, ec);
      end
    end
    exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
  endtask

  task automatic test_req1();
    int l;
    bit ok;
    rec_t e, o;
    send(1, "bEgin en", 25, l);
    push_exp(1, "bEgin en", l);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL req1_timeout no done");
    end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL req1_report got %s want %s", fmt(o), fmt(e));
      end
      checks++;
      if (o.res !== 1'b0 || o.len !== 16'd8) begin
        failures++;
        $display("FAIL req1_values got res=%0d len=%0d want res=0 len=8", o.res, o.len);
      end
    end
    exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
  endtask

  // 70 bytes: the first 64 form a balanced job; the dropped tail would add an
  // unmatched "end", so a correct truncated replay reports result=1.
  task automatic test_overflow();
    string s = "begin ";
    int l;
    bit ok;
    rec_t e, o;
    string ec, oc;
    for (int k = 0; k < 54; k++) s = {s, "z"};
    s = {s, " end", " end x"};
    send(0, s, 10, l);
    push_exp(0, s, l);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ovf_timeout no done");
    end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ec = exp_cap_q.pop_front(); oc = obs_cap_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ovf_report got %s want %s", fmt(o), fmt(e));
      end
      checks++;
      if (o.len !== 16'd70 || o.ovf !== 1'b1 || o.res !== 1'b1) begin
        failures++;
        $display("FAIL ovf_values got len=%0d ovf=%0d res=%0d want 70 1 1", o.len, o.ovf, o.res);
      end
      checks++;
      if (oc != ec) begin
        failures++;
        $display("FAIL ovf_stream got len %0d \"%s\" want len %0d", oc.len(), oc, ec.len());
      end
    end
    exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
  endtask

  task automatic test_single_byte();
    int l;
    bit ok;
    rec_t e, o;
    string ec, oc;
    send(0, "e", 0, l);
    push_exp(0, "e", l);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_timeout no done");
    end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ec = exp_cap_q.pop_front(); oc = obs_cap_q.pop_front();
      checks++;
      if (o.edge_c !== 32'(l + 4 + RL)) begin
        failures++;
        $display("FAIL single_timing got done edge %0d want %0d", o.edge_c, l + 4 + RL);
      end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single_report got %s want %s", fmt(o), fmt(e));
      end
      checks++;
      if (oc != ec) begin
        failures++;
        $display("FAIL single_stream got \"%s\" want \"%s\"", oc, ec);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || done_len !== 16'd1) begin
        failures++;
        $display("FAIL single_pulse got done=%0d len=%0d want done=0 len=1", done, done_len);
      end
    end
    exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
  endtask

  task automatic test_reset_mid_job();
    int l;
    int done_seen = 0;
    bit ok;
    rec_t e, o;
    send(0, "begin begin end end ", 0, l);
    repeat (3) @(negedge clk);  // now a few cycles into replay
    reset = 1'b1;
    #1;
    checks++;
    if ({chk_reset, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL midreset_ctrl got chk_reset,busy,done=%b want 100", {chk_reset, busy, done});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_done got done_cycles=%0d reports=%0d want 0 0", done_seen, obs_q.size());
    end
    obs_q.delete(); obs_cap_q.delete();
    send(1, "begin end", 20, l);
    push_exp(1, "begin end", l);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset_next_timeout no done");
    end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midreset_next_report got %s want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete(); exp_cap_q.delete(); obs_q.delete(); obs_cap_q.delete();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_bubbles();
    test_req1();
    test_overflow();
    test_single_byte();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
